// File: rtl/adc733_ctrl_if.sv
// Bundle of the host-side and core-side signals of adc733_ctrl.
// The master modport is the controller's view; slave is the environment's view.
interface adc733_ctrl_if #(
  parameter int NUM_CH = 6
);
  logic [63:0]       cfg_regs;
  logic              cfg_start;
  logic [15:0]       cw_data;
  logic              cw_valid;
  logic              cw_ack;
  logic [15:0]       smp_data;
  logic [2:0]        smp_ch;
  logic              smp_valid;
  logic              rd_en;
  logic [2:0]        rd_ch;
  logic [15:0]       rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] new_mask;
  logic              frame_done;
  logic              overrun;
  logic              busy;
  logic              cfg_err;

  modport master (
    input  cfg_regs, cfg_start, cw_ack, smp_data, smp_ch, smp_valid, rd_en, rd_ch,
    output cw_data, cw_valid, rd_data, rd_valid, new_mask, frame_done, overrun, busy, cfg_err
  );

  modport slave (
    output cfg_regs, cfg_start, cw_ack, smp_data, smp_ch, smp_valid, rd_en, rd_ch,
    input  cw_data, cw_valid, rd_data, rd_valid, new_mask, frame_done, overrun, busy, cfg_err
  );
endinterface

// File: rtl/adc733_ctrl.sv
// adc733 codec sequencer: programs CRA..CRH, enters data mode, then collects
// per-channel samples into holding registers for the host.
module adc733_ctrl #(
  parameter int         NUM_CH      = 6,
  parameter logic [2:0] DEV_ADDR    = 3'd0,
  parameter int         ACK_TIMEOUT = 1024,
  parameter int         MAX_RETRY   = 3
) (
  input  logic           clk,
  input  logic           rst,
  adc733_ctrl_if.master  bus
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    RESET_WAIT,
    LOAD,
    WAIT_ACK,
    DATAMODE,
    RUN,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d, retry_inc;
  logic [15:0]       cw_data_q, cw_data_d;
  logic              cw_valid_q, cw_valid_d;
  logic              busy_q, busy_d;
  logic              cfg_err_q, cfg_err_d;
  logic              waiting;

  logic [15:0]       hold_q [NUM_CH];
  logic [15:0]       hold_d [NUM_CH];
  logic [NUM_CH-1:0] new_mask_q, new_mask_d;
  logic              overrun_q, overrun_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              smp_acc;
  logic [NUM_CH-1:0] smp_sel, rd_sel;

  // Sequencer. In DATAMODE the state doubles as its own load step: with
  // cw_valid low it presents the data-mode word, with cw_valid high it waits.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    cw_data_d  = cw_data_q;
    cw_valid_d = cw_valid_q;
    cfg_err_d  = cfg_err_q;
    waiting    = 1'b0;
    retry_inc  = retry_q + 1'b1;

    if (bus.cfg_start) begin
      state_d    = LOAD;
      idx_d      = 3'd0;
      retry_d    = '0;
      cfg_err_d  = 1'b0;
      cw_valid_d = 1'b0;
    end else begin
      case (state_q)
        RESET_WAIT: begin
          state_d = LOAD;
          idx_d   = 3'd0;
        end
        LOAD: begin
          cw_data_d  = {2'b10, DEV_ADDR, idx_q, bus.cfg_regs[{idx_q, 3'b000} +: 8]};
          cw_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_ACK;
        end
        WAIT_ACK: waiting = 1'b1;
        DATAMODE: begin
          if (!cw_valid_q) begin
            cw_data_d  = {2'b00, DEV_ADDR, 3'd0, 8'h01};
            cw_valid_d = 1'b1;
            cnt_d      = '0;
          end else begin
            waiting = 1'b1;
          end
        end
        default: ;
      endcase

      if (waiting) begin
        if (bus.cw_ack) begin
          retry_d    = '0;
          cw_valid_d = 1'b0;
          if (state_q == DATAMODE) begin
            state_d = RUN;
          end else if (idx_q == 3'd7) begin
            state_d = DATAMODE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          cw_valid_d = 1'b0;
          if (retry_inc > RTY_W'(MAX_RETRY)) begin
            cfg_err_d = 1'b1;
            state_d   = HALT;
          end else begin
            retry_d = retry_inc;
            state_d = (state_q == DATAMODE) ? DATAMODE : LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Registered busy lines up with cw_valid on entry and drops right after the last ack.
    busy_d = (state_q inside {LOAD, WAIT_ACK, DATAMODE}) &&
             (state_d inside {LOAD, WAIT_ACK, DATAMODE});
  end

  assign smp_acc = (state_q == RUN) && bus.smp_valid && !bus.cfg_start;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign smp_sel[gi] = smp_acc && (bus.smp_ch == 3'(gi));
    assign rd_sel[gi]  = bus.rd_en && (bus.rd_ch == 3'(gi));
  end

  // A same-cycle read and sample returns the old value; the sample re-arms its flag.
  always_comb begin
    hold_d       = hold_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = bus.rd_en;
    frame_done_d = smp_sel[NUM_CH-1];
    new_mask_d   = (new_mask_q & ~rd_sel) | smp_sel;
    overrun_d    = overrun_q | (|(smp_sel & new_mask_q & ~rd_sel));
    for (int i = 0; i < NUM_CH; i++) begin
      if (smp_sel[i]) hold_d[i] = bus.smp_data;
    end
    if (bus.rd_en) begin
      rd_data_d = 16'h0000;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_sel[i]) rd_data_d = hold_q[i];
      end
    end
    if (bus.cfg_start) begin
      new_mask_d = '0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RESET_WAIT;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      retry_q      <= '0;
      cw_data_q    <= 16'h0000;
      cw_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      new_mask_q   <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      rd_data_q    <= 16'h0000;
      rd_valid_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= 16'h0000;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      cw_data_q    <= cw_data_d;
      cw_valid_q   <= cw_valid_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
      new_mask_q   <= new_mask_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.cw_data    = cw_data_q;
  assign bus.cw_valid   = cw_valid_q;
  assign bus.busy       = busy_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.new_mask   = new_mask_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_done = frame_done_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_adc733_ctrl.sv
// Directed bench for adc733_ctrl: bring-up, retry/halt, recovery, sample
// collection, overrun/collision, restart and asynchronous reset.
module tb_adc733_ctrl;
  localparam int NUM_CH      = 6;
  localparam int ACK_TIMEOUT = 64;
  localparam int MAX_RETRY   = 3;
  localparam logic [15:0] EXP_W [9] = '{16'h8000, 16'h8101, 16'h8202, 16'h8303,
                                        16'h8404, 16'h8505, 16'h8606, 16'h8707, 16'h0001};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  adc733_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

  adc733_ctrl #(
    .NUM_CH(NUM_CH), .DEV_ADDR(3'd0), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [43:0] all_outs();
    return {bus.cw_data, bus.cw_valid, bus.rd_data, bus.rd_valid, bus.new_mask,
            bus.frame_done, bus.overrun, bus.busy, bus.cfg_err};
  endfunction

  task automatic test_reset();
    bus.cfg_regs = 64'h0706050403020100;
    bus.cfg_start = 0; bus.cw_ack = 0; bus.smp_valid = 0; bus.smp_ch = 0;
    bus.smp_data = 0; bus.rd_en = 0; bus.rd_ch = 0;
    rst = 1;
    repeat (3) tick();
    n_checks++;
    if (all_outs() !== 44'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", all_outs());
    end
    rst = 0;
    tick();
    n_checks++;
    if (bus.cw_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_cycle1: cw_valid=%b busy=%b, expected 0 0", bus.cw_valid, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.cw_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_cycle2: cw_valid=%b busy=%b, expected 1 1", bus.cw_valid, bus.busy);
    end
  endtask

  task automatic test_bringup();
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (bus.cw_valid !== 1'b1 || bus.cw_data !== EXP_W[k]) begin
        n_fail++; $display("FAIL bringup_word%0d: valid=%b data=%h, expected 1 %h", k, bus.cw_valid, bus.cw_data, EXP_W[k]);
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL bringup_busy%0d: got %b, expected 1", k, bus.busy);
      end
      $display("bringup: word %0d = %h", k, bus.cw_data);
      repeat (19) tick();
      bus.cw_ack = 1; tick(); bus.cw_ack = 0;
      n_checks++;
      if (bus.cw_valid !== 1'b0) begin
        n_fail++; $display("FAIL bringup_gap%0d: cw_valid=%b, expected 0", k, bus.cw_valid);
      end
      if (k == 8) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++; $display("FAIL bringup_busy_fall: got %b, expected 0", bus.busy);
        end
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_samples();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.smp_valid = 1; bus.smp_ch = 3'(i); bus.smp_data = 16'h1000 + 16'(i);
      tick();
      n_checks++;
      if (bus.frame_done !== (i == NUM_CH - 1)) begin
        n_fail++; $display("FAIL sample_frame_done ch%0d: got %b, expected %b", i, bus.frame_done, (i == NUM_CH - 1));
      end
      $display("sample: ch%0d = %h", i, bus.smp_data);
    end
    bus.smp_valid = 0;
    tick();
    n_checks++;
    if (bus.frame_done !== 1'b0 || bus.new_mask !== 6'h3F || bus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL sample_mask: frame_done=%b new_mask=%h overrun=%b, expected 0 3f 0",
                         bus.frame_done, bus.new_mask, bus.overrun);
    end
    bus.rd_en = 1; bus.rd_ch = 3; tick(); bus.rd_en = 0;
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h1003 || bus.new_mask !== 6'h37) begin
      n_fail++; $display("FAIL read_ch3: valid=%b data=%h mask=%h, expected 1 1003 37", bus.rd_valid, bus.rd_data, bus.new_mask);
    end
    $display("read: ch3 = %h", bus.rd_data);
    bus.rd_en = 1; bus.rd_ch = 6; tick(); bus.rd_en = 0;
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL read_ch6: valid=%b data=%h, expected 1 0000", bus.rd_valid, bus.rd_data);
    end
    bus.smp_valid = 1; bus.smp_ch = 7; bus.smp_data = 16'hBEEF; tick(); bus.smp_valid = 0;
    n_checks++;
    if (bus.rd_valid !== 1'b0 || bus.new_mask !== 6'h37 || bus.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL sample_ch7_drop: rd_valid=%b mask=%h frame_done=%b, expected 0 37 0",
                         bus.rd_valid, bus.new_mask, bus.frame_done);
    end
  endtask

  task automatic test_collision();
    bus.rd_en = 1; bus.rd_ch = 4;
    bus.smp_valid = 1; bus.smp_ch = 4; bus.smp_data = 16'h2004;
    tick();
    bus.rd_en = 0; bus.smp_valid = 0;
    n_checks++;
    if (bus.rd_data !== 16'h1004 || bus.new_mask !== 6'h37 || bus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL collision_ch4: data=%h mask=%h overrun=%b, expected 1004 37 0",
                         bus.rd_data, bus.new_mask, bus.overrun);
    end
    bus.rd_en = 1; bus.rd_ch = 4; tick(); bus.rd_en = 0;
    n_checks++;
    if (bus.rd_data !== 16'h2004 || bus.new_mask !== 6'h27) begin
      n_fail++; $display("FAIL collision_reread: data=%h mask=%h, expected 2004 27", bus.rd_data, bus.new_mask);
    end
    $display("collision: ch4 reread = %h", bus.rd_data);
  endtask

  task automatic test_overrun();
    bus.smp_valid = 1; bus.smp_ch = 2; bus.smp_data = 16'h2002; tick(); bus.smp_valid = 0;
    n_checks++;
    if (bus.overrun !== 1'b1 || bus.new_mask !== 6'h27) begin
      n_fail++; $display("FAIL overrun_set: overrun=%b mask=%h, expected 1 27", bus.overrun, bus.new_mask);
    end
    bus.rd_en = 1; bus.rd_ch = 2; tick(); bus.rd_en = 0;
    n_checks++;
    if (bus.overrun !== 1'b1 || bus.rd_data !== 16'h2002) begin
      n_fail++; $display("FAIL overrun_sticky: overrun=%b data=%h, expected 1 2002", bus.overrun, bus.rd_data);
    end
  endtask

  task automatic test_retry();
    int   rises = 0;
    int   others = 0;
    int   rise_cyc[$];
    logic prev = 1'b0;
    bus.cfg_start = 1; tick(); bus.cfg_start = 0;
    n_checks++;
    if (bus.new_mask !== 6'h00 || bus.overrun !== 1'b0 || bus.cw_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_clear: mask=%h overrun=%b cw_valid=%b, expected 00 0 0",
                         bus.new_mask, bus.overrun, bus.cw_valid);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bus.cw_valid !== 1'b1 || bus.cw_data !== EXP_W[k]) begin
        n_fail++; $display("FAIL retry_pre_word%0d: valid=%b data=%h, expected 1 %h", k, bus.cw_valid, bus.cw_data, EXP_W[k]);
      end
      bus.cw_ack = 1; tick(); bus.cw_ack = 0; tick();
    end
    for (int c = 0; c < 300; c++) begin
      if (bus.cw_valid && !prev) begin
        if (bus.cw_data === 16'h8202) begin
          rises++; rise_cyc.push_back(c);
          $display("retry: CRC word sent at cycle %0d", c);
        end else begin
          others++;
        end
      end
      prev = bus.cw_valid;
      tick();
    end
    n_checks++;
    if (rises != 1 + MAX_RETRY || others != 0) begin
      n_fail++; $display("FAIL retry_count: crc_sends=%0d other_words=%0d, expected %0d 0", rises, others, 1 + MAX_RETRY);
    end
    for (int i = 1; i < rise_cyc.size(); i++) begin
      // timeout window plus the one-cycle valid gap before the re-send
      n_checks++;
      if (rise_cyc[i] - rise_cyc[i-1] != ACK_TIMEOUT + 1) begin
        n_fail++; $display("FAIL retry_spacing%0d: got %0d, expected %0d", i, rise_cyc[i] - rise_cyc[i-1], ACK_TIMEOUT + 1);
      end
    end
    n_checks++;
    if (bus.cfg_err !== 1'b1 || bus.cw_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL retry_halt: cfg_err=%b cw_valid=%b busy=%b, expected 1 0 0", bus.cfg_err, bus.cw_valid, bus.busy);
    end
  endtask

  task automatic test_recovery();
    bus.cfg_start = 1; tick(); bus.cfg_start = 0;
    n_checks++;
    if (bus.cfg_err !== 1'b0 || bus.cw_valid !== 1'b0) begin
      n_fail++; $display("FAIL recovery_clear: cfg_err=%b cw_valid=%b, expected 0 0", bus.cfg_err, bus.cw_valid);
    end
    tick();
    n_checks++;
    if (bus.cw_valid !== 1'b1 || bus.cw_data !== 16'h8000 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL recovery_cra: valid=%b data=%h busy=%b, expected 1 8000 1", bus.cw_valid, bus.cw_data, bus.busy);
    end
    $display("recovery: restarted with %h", bus.cw_data);
  endtask

  task automatic test_restart();
    for (int k = 0; k < 4; k++) begin
      bus.cw_ack = 1; tick(); bus.cw_ack = 0; tick();
    end
    n_checks++;
    if (bus.cw_valid !== 1'b1 || bus.cw_data !== 16'h8404) begin
      n_fail++; $display("FAIL restart_cre: valid=%b data=%h, expected 1 8404", bus.cw_valid, bus.cw_data);
    end
    repeat (3) tick();
    bus.cfg_start = 1; tick(); bus.cfg_start = 0;
    n_checks++;
    if (bus.cw_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_gap: cw_valid=%b, expected 0", bus.cw_valid);
    end
    tick();
    n_checks++;
    if (bus.cw_valid !== 1'b1 || bus.cw_data !== 16'h8000) begin
      n_fail++; $display("FAIL restart_cra: valid=%b data=%h, expected 1 8000", bus.cw_valid, bus.cw_data);
    end
    $display("restart: CRE interrupted, resent %h", bus.cw_data);
  endtask

  task automatic test_midword_reset();
    #2 rst = 1;
    #1;
    n_checks++;
    if (all_outs() !== 44'h0) begin
      n_fail++; $display("FAIL midword_reset: got %h, expected 0", all_outs());
    end
    tick();
    rst = 0;
    tick(); tick();
    n_checks++;
    if (bus.cw_valid !== 1'b1 || bus.cw_data !== 16'h8000) begin
      n_fail++; $display("FAIL post_reset_cra: valid=%b data=%h, expected 1 8000", bus.cw_valid, bus.cw_data);
    end
    $display("reset: outputs cleared, bring-up resumed with %h", bus.cw_data);
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_samples();
    test_collision();
    test_overrun();
    test_retry();
    test_recovery();
    test_restart();
    test_midword_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
